// File: rtl/adder_mw_seq.sv
// adder_mw_seq: wide (WORDS x 16-bit) adder built by sequencing one external
// 16-bit flag adder over the operand words, least-significant word first.
// The carry is chained through carry_r; zero/parity are accumulated per word
// and the signed overflow is taken from the top word only.
// Optional feature macro: ADDER_MW_SUB_EN (adds in_sub, computes A - B).
module adder_mw_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORDS*16-1:0]   in_a,
  input  logic [WORDS*16-1:0]   in_b,
  input  logic                  in_cin,
`ifdef ADDER_MW_SUB_EN
  input  logic                  in_sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORDS*16-1:0]   out_sum,
  output logic                  out_carry,
  output logic                  out_zero,
  output logic                  out_sign,
  output logic                  out_parity,
  output logic                  out_overflow,
  output logic [15:0]           add_a,
  output logic [15:0]           add_b,
  output logic                  add_cin,
  input  logic [15:0]           add_y,
  input  logic                  add_carry,
  input  logic                  add_overflow
);

  localparam int W  = WORDS * 16;
  localparam int IW = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Even-parity bit of one adder result word.
  function automatic logic par16(input logic [15:0] v);
    return ^v;
  endfunction

  state_t          state_r, state_s;
  logic [W-1:0]    a_r, b_r, sum_r, sum_next_s;
  logic [IW-1:0]   idx_r;
  logic            carry_r, zero_r, par_r;
  logic            zero_next_s, par_next_s, last_s, sub_s;
  int              base_s;

`ifdef ADDER_MW_SUB_EN
  logic            sub_r;
  assign sub_s = sub_r;
`else
  assign sub_s = 1'b0;
`endif

  assign base_s = 16 * int'(idx_r);
  assign last_s = (idx_r == IW'(WORDS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode, handshake flags and adder operand steering.
  always_comb begin
    state_s   = state_r;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = 16'h0000;
    add_b     = 16'h0000;
    add_cin   = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        add_a   = a_r[base_s +: 16];
        add_b   = b_r[base_s +: 16] ^ {16{sub_s}};
        add_cin = carry_r;
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Partial result after merging the current adder word.
  always_comb begin
    sum_next_s = sum_r;
    if (state_r == RUN) begin
      sum_next_s[base_s +: 16] = add_y;
    end else begin
      sum_next_s = sum_r;
    end
    zero_next_s = zero_r & (add_y == 16'h0000);
    par_next_s  = par_r ^ par16(add_y);
  end

  // Operand latch, per-word accumulation and result capture on the last word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r          <= '0;
      b_r          <= '0;
      sum_r        <= '0;
      idx_r        <= '0;
      carry_r      <= 1'b0;
      zero_r       <= 1'b0;
      par_r        <= 1'b0;
`ifdef ADDER_MW_SUB_EN
      sub_r        <= 1'b0;
`endif
      out_sum      <= '0;
      out_carry    <= 1'b0;
      out_zero     <= 1'b0;
      out_sign     <= 1'b0;
      out_parity   <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r    <= in_a;
            b_r    <= in_b;
            idx_r  <= '0;
            zero_r <= 1'b1;
            par_r  <= 1'b0;
`ifdef ADDER_MW_SUB_EN
            sub_r   <= in_sub;
            carry_r <= in_sub | in_cin;
`else
            carry_r <= in_cin;
`endif
          end
        end
        RUN: begin
          sum_r   <= sum_next_s;
          carry_r <= add_carry;
          zero_r  <= zero_next_s;
          par_r   <= par_next_s;
          if (last_s) begin
            // Results are copied out here so they stay put while the
            // working registers are reused by the next request.
            out_sum      <= sum_next_s;
            out_carry    <= add_carry;
            out_zero     <= zero_next_s;
            out_sign     <= sum_next_s[W-1];
            out_parity   <= par_next_s;
            out_overflow <= add_overflow;
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_mw_seq.sv
// Testbench for adder_mw_seq (WORDS=4): directed table, random vectors against
// a full-width arithmetic model, backpressure and mid-run reset sequences.
module tb_adder_mw_seq;

  localparam int WORDS = 4;
  localparam int W     = WORDS * 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_carry, out_zero, out_sign, out_parity, out_overflow;
  logic [15:0]  add_a, add_b, add_y;
  logic         add_cin, add_carry, add_overflow;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // External 16-bit flag adder.
  assign {add_carry, add_y} = {1'b0, add_a} + {1'b0, add_b} + {16'h0000, add_cin};
  assign add_overflow = (add_a[15] == add_b[15]) && (add_y[15] != add_a[15]);

  adder_mw_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef ADDER_MW_SUB_EN
    .in_sub(in_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_zero(out_zero),
    .out_sign(out_sign), .out_parity(out_parity), .out_overflow(out_overflow),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_y(add_y), .add_carry(add_carry), .add_overflow(add_overflow)
  );

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] sum;
    logic         carry, zero, sign, parity, ovf;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain wide arithmetic on the whole operand.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, output vec_t v);
    logic [W:0]   s;
    logic [W-1:0] bb;
    bb = sub ? ~b : b;
    s = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    v.a = a; v.b = b; v.cin = cin;
    v.sum = s[W-1:0];
    v.carry = s[W];
    v.zero = (s[W-1:0] == '0);
    v.sign = s[W-1];
    v.parity = ^s[W-1:0];
    v.ovf = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
  endtask

  // Issue a request and wait for out_valid; checks the latency.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    check("in_ready_before_issue", {63'd0, in_ready}, 64'd1);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    // DONE is the (WORDS+1)th cycle counting the accepting cycle itself.
    check("latency", 64'(n), 64'(WORDS));
  endtask

  task automatic check_result(input string tag, input vec_t v);
    check({tag, "_valid"},  {63'd0, out_valid},    64'd1);
    check({tag, "_sum"},    out_sum,               v.sum);
    check({tag, "_carry"},  {63'd0, out_carry},    {63'd0, v.carry});
    check({tag, "_zero"},   {63'd0, out_zero},     {63'd0, v.zero});
    check({tag, "_sign"},   {63'd0, out_sign},     {63'd0, v.sign});
    check({tag, "_parity"}, {63'd0, out_parity},   {63'd0, v.parity});
    check({tag, "_ovf"},    {63'd0, out_overflow}, {63'd0, v.ovf});
  endtask

  task automatic retire();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ready_after_retire", {63'd0, in_ready}, 64'd1);
    check("valid_after_retire", {63'd0, out_valid}, 64'd0);
  endtask

  vec_t tbl[6];
  vec_t v;

  initial begin
    tbl[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset state.
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_sum",   out_sum, 64'd0);
    check("rst_flags", {59'd0, out_carry, out_zero, out_sign, out_parity, out_overflow}, 64'd0);
    check("rst_add_a", {48'd0, add_a}, 64'd0);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0);
      check_result($sformatf("tbl%0d", i), tbl[i]);
      retire();
    end

    // Random vectors against the wide model.
    for (int i = 0; i < 40; i++) begin
      model({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)), 1'b0, v);
      if (i % 8 == 0) v.b = ~v.a;
      model(v.a, v.b, v.cin, 1'b0, v);
      issue(v.a, v.b, v.cin, 1'b0);
      check_result($sformatf("rnd%0d", i), v);
      retire();
    end

    // Backpressure: results hold, new requests are ignored.
    model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, v);
    issue(v.a, v.b, v.cin, 1'b0);
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0];
      in_a = {$urandom, $urandom};
      in_b = {$urandom, $urandom};
      tick();
      check("bp_valid", {63'd0, out_valid}, 64'd1);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_sum", out_sum, v.sum);
    end
    in_valid = 1'b0;
    check_result("bp", v);
    retire();
    check("bp_hold_sum", out_sum, v.sum);
    tick();
    check("bp_no_accept", {62'd0, out_valid, in_ready}, 64'd1);
    check("bp_idle_add_b", {48'd0, add_b}, 64'd0);

    // Reset while idx == 2 in RUN.
    in_a = 64'hAAAA_AAAA_AAAA_AAAA; in_b = 64'h5555; in_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("mid_add_a_word2", {48'd0, add_a}, 64'h0000_0000_0000_AAAA);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < WORDS + 3; i++) begin
        seen = seen | out_valid;
        tick();
      end
      check("mid_rst_no_valid", {63'd0, seen}, 64'd0);
    end
    model(64'd1, 64'd2, 1'b0, 1'b0, v);
    issue(64'd1, 64'd2, 1'b0, 1'b0);
    check("post_rst_sum", out_sum, 64'd3);
    check_result("post_rst", v);
    retire();

`ifdef ADDER_MW_SUB_EN
    // Subtraction: in_cin is ignored, carry means no borrow.
    v = '{64'd5, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    issue(64'd5, 64'd7, 1'b0, 1'b1);
    check_result("sub", v);
    retire();
    for (int i = 0; i < 10; i++) begin
      model({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)), 1'b1, v);
      issue(v.a, v.b, v.cin, 1'b1);
      check_result($sformatf("rsub%0d", i), v);
      retire();
    end
    in_sub = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
